tt_pm_loader: RTL
=================

TT_PM_LOADER -- requirements
Module: tt_pm_loader

Interface
REQ-001 Parameter DATAWIDTH, default 32, program-memory word width; SHALL be a multiple of 8 and at least 16; NB = DATAWIDTH/8 bytes per word.
REQ-002 Parameter ADDWIDTH, default 7, program-memory address width.
REQ-003 Derived SELW = max(1, clog2(NB)), width of byte-select and byte-count fields.
REQ-004 Ports SHALL be exactly as follows.
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_en  input  1  1 = loader mode (CPU held), 0 = run mode.
- byte_valid  input  1  one-cycle strobe, byte_in valid.
- byte_in  input  8  instruction byte.
- addr_load  input  1  one-cycle strobe, load write address from addr_in.
- addr_in  input  ADDWIDTH  new write address.
- pm_we  output  1  program-memory write strobe.
- pm_addr  output  ADDWIDTH  program-memory write address.
- pm_wdata  output  DATAWIDTH  assembled instruction word.
- cpu_run  output  1  CPU enable, 1 only in RUN.
- result_in  input  DATAWIDTH  CPU ALU result.
- result_sel  input  SELW  byte select for result_byte.
- result_byte  output  8  registered selected result byte.
- chk_out  output  8  load checksum (see Configuration).

Function
REQ-005 FSM states SHALL be IDLE, COLLECT, WRITE and RUN.
REQ-006 IDLE: load_en=1 -> COLLECT, load_en=0 -> RUN.
REQ-007 RUN: cpu_run=1; load_en=1 -> COLLECT, with cpu_run=0 from the next cycle.
REQ-008 COLLECT: each byte_valid SHALL write byte_in into pm_wdata bits [8k+7:8k], k = byte count; count increments; little-endian, first byte = LSB.
REQ-009 COLLECT: byte_valid with count = NB-1 SHALL move to WRITE and reset count to 0.
REQ-010 WRITE SHALL last exactly one cycle, with pm_we=1 and pm_addr/pm_wdata stable; pm_we rises the cycle after the NB-th byte is sampled.
REQ-011 After WRITE the write address SHALL increment by 1 modulo 2^ADDWIDTH (wrap to 0); next state is COLLECT if load_en=1, else RUN.
REQ-012 byte_valid during WRITE SHALL be accepted as byte 0 of the next word; sustained throughput is one byte per cycle with no byte dropped.
REQ-013 load_en=0 in COLLECT SHALL discard the partial word, clear count and move to RUN; no pm_we is issued.
REQ-014 addr_load in IDLE or COLLECT SHALL set the write address to addr_in and clear count, discarding any partial word.
REQ-015 If byte_valid coincides with addr_load, the address SHALL load and that byte becomes byte 0 of the new word.
REQ-016 addr_load in WRITE or RUN SHALL be ignored.
REQ-017 byte_valid in IDLE or RUN SHALL be ignored.
REQ-018 pm_addr SHALL always show the current write address.
REQ-019 pm_we SHALL be 0 in every state except WRITE.
REQ-020 result_byte SHALL register result_in byte result_sel every cycle (1-cycle latency); result_sel >= NB yields 0x00.

Reset
REQ-021 rst=1 SHALL asynchronously set: state IDLE, count 0, write address 0, pm_wdata 0, pm_we 0, cpu_run 0, result_byte 0x00, chk_out 0x00.
REQ-022 Reset during COLLECT or WRITE SHALL abort the word; no pm_we is issued after rst asserts.

Configuration
REQ-023 With macro PM_CHECKSUM_EN defined, chk_out SHALL be the running XOR of all bytes accepted since the last entry into COLLECT from IDLE or RUN; it clears on that entry and holds its value in RUN.
REQ-024 Without PM_CHECKSUM_EN, chk_out SHALL be constant 0x00 and no checksum register SHALL be built.

Verification (DATAWIDTH=32, ADDWIDTH=7)
REQ-025 Reset, then load_en=1, bytes 0x13,0x05,0x10,0x00 -> one pm_we pulse the cycle after byte 4, pm_addr=0x00, pm_wdata=0x00100513; pm_addr then reads 0x01.
REQ-026 addr_load with addr_in=0x7F, then 8 back-to-back bytes -> two pm_we pulses at pm_addr 0x7F and then 0x00 (wrap), no byte lost.
REQ-027 2 bytes, then load_en=0 -> no pm_we, cpu_run=1 next cycle; reload 4 bytes -> word written at the unchanged address.
REQ-028 result_in=0xA1B2C3D4, result_sel=2 -> result_byte=0xB2 one cycle later; result_sel=3 -> 0xA1.
REQ-029 rst pulsed with 3 of 4 bytes loaded -> all outputs at reset values, no pm_we, pm_addr=0.
REQ-030 PM_CHECKSUM_EN defined, bytes 0x13,0x05,0x10,0x00 -> chk_out=0x06; macro undefined -> chk_out=0x00.

Source files
------------

// File: rtl/tt_pm_loader.sv
// tt_pm_loader: serial byte loader assembling program-memory words, plus CPU run gate and result byte tap.
// Optional load checksum on chk_out when PM_CHECKSUM_EN is defined.
module tt_pm_loader #(
  parameter int DATAWIDTH = 32,
  parameter int ADDWIDTH = 7,
  localparam int NB = DATAWIDTH / 8,
  localparam int SELW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  input  logic                 addr_load,
  input  logic [ADDWIDTH-1:0]  addr_in,
  output logic                 pm_we,
  output logic [ADDWIDTH-1:0]  pm_addr,
  output logic [DATAWIDTH-1:0] pm_wdata,
  output logic                 cpu_run,
  input  logic [DATAWIDTH-1:0] result_in,
  input  logic [SELW-1:0]      result_sel,
  output logic [7:0]           result_byte,
  output logic [7:0]           chk_out
);
  localparam logic [1:0] S_IDLE = 2'd0, S_COLLECT = 2'd1, S_WRITE = 2'd2, S_RUN = 2'd3;
  logic [1:0]           r_state, w_state;
  logic [SELW-1:0]      r_cnt, w_cnt, w_pos;
  logic [ADDWIDTH-1:0]  r_addr, w_addr;
  logic [DATAWIDTH-1:0] r_wdata, w_wdata;
  logic [7:0]           r_res, w_rb;
  logic                 w_acc, w_aload, w_clr;
  assign pm_we = r_state == S_WRITE;
  assign cpu_run = r_state == S_RUN;
  assign pm_addr = r_addr;
  assign pm_wdata = r_wdata;
  assign result_byte = r_res;
  // A byte arriving in WRITE or alongside addr_load always starts a fresh word at lane 0.
  always_comb begin
    w_acc = byte_valid && load_en && (r_state == S_COLLECT || r_state == S_WRITE);
    w_aload = addr_load && (r_state == S_IDLE || r_state == S_COLLECT);
    w_pos = (w_aload || r_state == S_WRITE) ? '0 : r_cnt;
    w_state = r_state;
    w_cnt = '0;
    w_addr = w_aload ? addr_in : r_addr;
    w_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state = load_en ? S_COLLECT : S_RUN;
        w_clr = load_en;
      end
      S_COLLECT: begin
        w_state = !load_en ? S_RUN : (w_acc && w_pos == SELW'(NB - 1)) ? S_WRITE : S_COLLECT;
        w_cnt = (load_en && w_acc && w_pos != SELW'(NB - 1)) ? w_pos + 1'b1 : '0;
      end
      S_WRITE: begin
        w_state = load_en ? S_COLLECT : S_RUN;
        w_cnt = w_acc ? SELW'(1) : '0;
        w_addr = r_addr + 1'b1;
      end
      default: begin
        w_state = load_en ? S_COLLECT : S_RUN;
        w_clr = load_en;
      end
    endcase
    w_wdata = r_wdata;
    for (int i = 0; i < NB; i++)
      if (w_acc && w_pos == SELW'(i)) w_wdata[8*i +: 8] = byte_in;
    w_rb = 8'h00;
    for (int i = 0; i < NB; i++)
      if (result_sel == SELW'(i)) w_rb = result_in[8*i +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_res <= 8'h00;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_addr <= w_addr;
      r_wdata <= w_wdata;
      r_res <= w_rb;
    end
  end
`ifdef PM_CHECKSUM_EN
  logic [7:0] r_chk;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_chk <= 8'h00;
    else r_chk <= w_clr ? 8'h00 : w_acc ? r_chk ^ byte_in : r_chk;
  end
  assign chk_out = r_chk;
`else
  logic w_unused_clr;
  assign w_unused_clr = w_clr;
  assign chk_out = 8'h00;
`endif
endmodule
